// File: rtl/combo_sweep_ctrl_pkg.sv
// rtl/combo_sweep_ctrl_pkg.sv - shared definitions for the combo truth-table sweep controller
//
// Purpose: FSM state encodings, default width of the combo input vector,
//          reference truth table of combo, and a reference model of combo.
// Ports:   none (package).
package combo_sweep_ctrl_pkg;

  localparam int          COMBO_N_IN = 5;
  localparam logic [31:0] COMBO_TT   = 32'hFF141414;

  // 2'd3 is unused; the FSM treats it as illegal and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_t;

  // z = a&b | (c^d)&~e with v = {a,b,c,d,e}.
  function automatic logic combo_ref(input logic [COMBO_N_IN-1:0] v);
    return (v[4] & v[3]) | ((v[2] ^ v[1]) & ~v[0]);
  endfunction

endpackage

// File: rtl/combo_sweep_ctrl_hold_timer.sv
// rtl/combo_sweep_ctrl_hold_timer.sv - per-vector hold counter for the sweep controller
//
// Purpose: counts cycles while enabled and flags the last cycle of each
//          HOLD-cycle window, then wraps to zero for the next vector.
// Ports:
//   clk   in  clock, rising edge
//   rst   in  synchronous active-high reset
//   clr   in  restart the window (sweep start)
//   en    in  count enable (FSM in RUN)
//   tick  out high on the final cycle of the hold window
module hold_timer #(
  parameter int HOLD = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int            CW   = $clog2(HOLD + 1);
  localparam logic [CW-1:0] LAST = CW'(HOLD - 1);

  logic [CW-1:0] count_q;

  // Combinational so the sample lands on the same edge that closes the window.
  assign tick = en && (count_q == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_q <= '0;
    end else if (en) begin
      if (count_q == LAST) begin
        count_q <= '0;
      end else begin
        count_q <= count_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/combo_sweep_ctrl.sv
// rtl/combo_sweep_ctrl.sv - drives every input vector into combo and collects its truth table
//
// Purpose: on start, steps vec through 0..2^N_IN-1, holding each for HOLD
//          cycles, samples z on the last hold cycle into tbl[vec], then
//          raises done and waits for ack.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset, highest priority
//   start  in   sweep request, honoured only in IDLE
//   z      in   combo output for the current vec
//   ack    in   table consumed, honoured only in DONE
//   vec    out  registered vector {a,b,c,d,e} driven to combo
//   busy   out  sweep in progress
//   done   out  tbl complete and stable
//   tbl    out  tbl[k] = z observed while vec == k
module combo_sweep_ctrl
  import combo_sweep_ctrl_pkg::*;
#(
  parameter int N_IN = COMBO_N_IN,
  parameter int HOLD = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 z,
  input  logic                 ack,
  output logic [N_IN-1:0]      vec,
  output logic                 busy,
  output logic                 done,
  output logic [(2**N_IN)-1:0] tbl
);

  localparam int              N_VEC  = 2 ** N_IN;
  localparam logic [N_IN-1:0] K_LAST = '1;

  state_t           state_q;
  state_t           state_d;
  logic [N_IN-1:0]  k_q;
  logic [N_VEC-1:0] tbl_q;
  logic             tick;
  logic             accept;

  assign accept = (state_q == ST_IDLE) && start;

  hold_timer #(
    .HOLD (HOLD)
  ) u_hold_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (state_q == ST_RUN),
    .tick (tick)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; ack beats start in DONE simply because start is not
  // looked at there, so a simultaneous start is dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (tick && (k_q == K_LAST)) state_d = ST_DONE;
      ST_DONE: if (ack) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode the registered state only, so no input reaches them.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_RUN:  busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Vector index and table. k stops at the terminal vector rather than
  // wrapping, so vec parks there until the next sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q   <= '0;
      tbl_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            k_q   <= '0;
            tbl_q <= '0;
          end
        end
        ST_RUN: begin
          if (tick) begin
            tbl_q[k_q] <= z;
            if (k_q != K_LAST) begin
              k_q <= k_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign vec = k_q;
  assign tbl = tbl_q;

endmodule
